// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - keypad scanner pin and key-event bundle
// Purpose: groups the matrix pins and the key-event outputs of keypad_matrix_scanner.
// Signals:
//   en          scan enable (consumer -> scanner)
//   key_row     row sense lines, active-low (keypad -> scanner)
//   key_col     column drive, active-low one-cold (scanner -> keypad)
//   key_code    accepted key index, col*NUM_ROWS+row
//   key_valid   one-cycle pulse on acceptance (or repeat)
//   key_release one-cycle pulse when the held key is released
//   key_held    level, high while an accepted key is pressed
// Modports: master = scanner side, slave = consumer/keypad side.
interface keypad_matrix_scanner_if #(
    parameter int NUM_COLS = 4,
    parameter int NUM_ROWS = 5
);
    localparam int CW = $clog2(NUM_ROWS * NUM_COLS);

    logic                en;
    logic [NUM_ROWS-1:0] key_row;
    logic [NUM_COLS-1:0] key_col;
    logic [CW-1:0]       key_code;
    logic                key_valid;
    logic                key_release;
    logic                key_held;

    modport master (
        input  en, key_row,
        output key_col, key_code, key_valid, key_release, key_held
    );

    modport slave (
        output en, key_row,
        input  key_col, key_code, key_valid, key_release, key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - debounced keypad matrix column scanner
// Purpose: drives matrix columns one-cold, samples synchronized rows once per
//   column dwell, picks the lowest pressed code per frame and debounces it
//   over DEBOUNCE_FRAMES frames before reporting press/release events.
// Ports:
//   clk   clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   keypad_matrix_scanner_if.master (en, key_row in; key_col, key_code,
//         key_valid, key_release, key_held out)
// Optional feature: define KEYPAD_SCAN_REPEAT_EN for auto-repeat of key_valid
//   every REPEAT_FRAMES frames while the accepted key stays pressed.
module keypad_matrix_scanner #(
    parameter int NUM_COLS        = 4,
    parameter int NUM_ROWS        = 5,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input logic                    clk,
    input logic                    rstn,
    keypad_matrix_scanner_if.master bus
);
    localparam int CW  = $clog2(NUM_ROWS * NUM_COLS);
    localparam int CIW = $clog2(NUM_COLS);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int RW  = $clog2(NUM_ROWS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state;
    logic [NUM_ROWS-1:0] row_s1, row_s2;
    logic [CIW-1:0]      col_idx;
    logic [DW-1:0]       div_cnt;
    logic                frame_found;
    logic [CW-1:0]       frame_code;
    logic                prev_none;
    logic [CW-1:0]       prev_code;
    logic [3:0]          stab_cnt;
    logic [NUM_COLS-1:0] key_col_q;
    logic [CW-1:0]       key_code_q;
    logic                key_valid_q, key_release_q, key_held_q;
`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_FRAMES + 1);
    logic [RPW-1:0]      rep_cnt;
`endif

    logic                col_hit;
    logic [RW-1:0]       col_row;
    logic                cand_none;
    logic [CW-1:0]       cand_code;
    logic                same_cand;
    logic [3:0]          stab_next;
    logic                stable;
    logic                last_dwell;
    logic                frame_end;
    logic [CIW-1:0]      next_col;

    always_comb begin
        col_hit = ~&row_s2;
        col_row = '0;
        // Descending loop so the lowest pressed row wins.
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r]) col_row = RW'(r);
        end
        // Columns are visited in ascending order, so an earlier hit in this
        // frame always has the lower code.
        cand_none = !(frame_found || col_hit);
        cand_code = frame_found ? frame_code
                                : CW'(int'(col_idx) * NUM_ROWS + int'(col_row));
        same_cand = cand_none ? prev_none : (!prev_none && prev_code == cand_code);
        stab_next = same_cand ? ((stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1) : 4'd1;
        stable    = stab_next >= 4'(DEBOUNCE_FRAMES);
        last_dwell = div_cnt == DW'(SCAN_DIV - 1);
        frame_end  = last_dwell && (col_idx == CIW'(NUM_COLS - 1));
        next_col   = (col_idx == CIW'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            row_s1        <= '1;
            row_s2        <= '1;
            col_idx       <= '0;
            div_cnt       <= '0;
            frame_found   <= 1'b0;
            frame_code    <= '0;
            prev_none     <= 1'b1;
            prev_code     <= '0;
            stab_cnt      <= '0;
            key_col_q     <= '1;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            row_s1        <= bus.key_row;
            row_s2        <= row_s1;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state     <= SCAN;
                        key_col_q <= ~NUM_COLS'(1);
                    end
                end
                SCAN: begin
                    if (!bus.en) begin
                        // Abandon the frame; the held key is dropped silently.
                        state       <= IDLE;
                        key_col_q   <= '1;
                        col_idx     <= '0;
                        div_cnt     <= '0;
                        frame_found <= 1'b0;
                        prev_none   <= 1'b1;
                        prev_code   <= '0;
                        stab_cnt    <= '0;
                        key_held_q  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        rep_cnt     <= '0;
`endif
                    end else if (!last_dwell) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt   <= '0;
                        col_idx   <= next_col;
                        key_col_q <= ~(NUM_COLS'(1) << next_col);
                        if (col_hit && !frame_found) begin
                            frame_found <= 1'b1;
                            frame_code  <= cand_code;
                        end
                        if (frame_end) begin
                            frame_found <= 1'b0;
                            prev_none   <= cand_none;
                            prev_code   <= cand_code;
                            stab_cnt    <= stab_next;
                            if (stable && !cand_none && (!key_held_q || cand_code != key_code_q)) begin
                                key_code_q  <= cand_code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
                                rep_cnt     <= '0;
`endif
                            end else if (stable && cand_none && key_held_q) begin
                                key_release_q <= 1'b1;
                                key_held_q    <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                                rep_cnt       <= '0;
`endif
                            end
`ifdef KEYPAD_SCAN_REPEAT_EN
                            else if (!cand_none && key_held_q && cand_code == key_code_q) begin
                                if (rep_cnt == RPW'(REPEAT_FRAMES - 1)) begin
                                    rep_cnt     <= '0;
                                    key_valid_q <= 1'b1;
                                end else begin
                                    rep_cnt <= rep_cnt + 1'b1;
                                end
                            end else begin
                                rep_cnt <= '0;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.key_col     = key_col_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_release = key_release_q;
    assign bus.key_held    = key_held_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed table-driven bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;
    localparam int NC = 4;
    localparam int NR = 5;
    localparam int FRAME = 16;
`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int LONG_HOLD_PULSES = 4;
`else
    localparam int LONG_HOLD_PULSES = 1;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NC*NR-1:0] pressed = '0;
    logic [NR-1:0] rows;

    keypad_matrix_scanner_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) bus ();

    keypad_matrix_scanner #(
        .NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_DIV(4),
        .DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its driven-low column.
    always_comb begin
        rows = '1;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (!bus.key_col[c] && pressed[c*NR+r]) rows[r] = 1'b0;
    end
    assign bus.key_row = rows;

    typedef struct {
        string            name;
        logic [NC*NR-1:0] press;
        int               frames;
        int               exp_code;
        int               exp_held;
        int               exp_valid;
        int               exp_rel;
    } vec_t;

    vec_t vecs[11];
    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int rel_cnt = 0;

    task automatic step();
        @(negedge clk);
        if (bus.key_valid) valid_cnt++;
        if (bus.key_release) rel_cnt++;
        if (bus.key_valid && bus.key_release) begin
            n_err++;
            $display("FAIL pulse_overlap: valid=1 release=1 required not both at %0t", $time);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int v0, r0, waited;
        logic [3:0] ecol;

        vecs[0]  = '{"bounce_2f",      20'h00080,  2, 0,  0, 0, 0};
        vecs[1]  = '{"empty_3f",       20'h00000,  3, 0,  0, 0, 0};
        vecs[2]  = '{"press7_5f",      20'h00080,  5, 7,  1, 1, 0};
        vecs[3]  = '{"release7_3f",    20'h00000,  3, 7,  0, 0, 1};
        vecs[4]  = '{"press4_15_4f",   20'h08010,  4, 4,  1, 1, 0};
        vecs[5]  = '{"release4_3f",    20'h00000,  3, 4,  0, 0, 1};
        vecs[6]  = '{"press15_4f",     20'h08000,  4, 15, 1, 1, 0};
        vecs[7]  = '{"change_to4_3f",  20'h00010,  3, 4,  1, 1, 0};
        vecs[8]  = '{"release_2f",     20'h00000,  2, 4,  1, 0, 0};
        vecs[9]  = '{"release_1f",     20'h00000,  1, 4,  0, 0, 1};
        vecs[10] = '{"hold7_30f",      20'h00080, 30, 7,  1, LONG_HOLD_PULSES, 0};

        bus.en = 1'b0;
        repeat (3) step();
        chk("rst_key_col", bus.key_col, 4'hF);
        chk("rst_key_code", bus.key_code, 0);
        chk("rst_key_valid", bus.key_valid, 0);
        chk("rst_key_release", bus.key_release, 0);
        chk("rst_key_held", bus.key_held, 0);

        rstn = 1'b1;
        step();
        step();
        chk("idle_key_col", bus.key_col, 4'hF);

        // One empty frame: column walk with four cycles per column.
        bus.en = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            ecol = ~(4'b0001 << (i / 4));
            chk("colseq", bus.key_col, ecol);
        end
        step();
        chk("empty_no_valid", valid_cnt, 0);
        chk("empty_no_release", rel_cnt, 0);

        // Each vector starts on the first cycle of a frame.
        for (int k = 0; k < 11; k++) begin
            pressed = vecs[k].press;
            v0 = valid_cnt;
            r0 = rel_cnt;
            repeat (vecs[k].frames * FRAME) step();
            chk({vecs[k].name, "_code"},    bus.key_code,  vecs[k].exp_code);
            chk({vecs[k].name, "_held"},    bus.key_held,  vecs[k].exp_held);
            chk({vecs[k].name, "_valid"},   valid_cnt - v0, vecs[k].exp_valid);
            chk({vecs[k].name, "_release"}, rel_cnt - r0,   vecs[k].exp_rel);
        end

        // Disable mid-frame while a key is held.
        repeat (7) step();
        v0 = valid_cnt;
        r0 = rel_cnt;
        bus.en = 1'b0;
        step();
        chk("endrop_key_col", bus.key_col, 4'hF);
        chk("endrop_held", bus.key_held, 0);
        repeat (20) step();
        chk("endrop_no_release", rel_cnt - r0, 0);
        chk("endrop_no_valid", valid_cnt - v0, 0);

        // Re-enable with key 7 still pressed: starts at column 0, re-accepts.
        bus.en = 1'b1;
        step();
        chk("reen_col0", bus.key_col, 4'hE);
        v0 = valid_cnt;
        waited = 0;
        while (valid_cnt == v0 && waited < 200) begin
            step();
            waited++;
        end
        chk("reen_accept", valid_cnt - v0, 1);
        chk("reen_code", bus.key_code, 7);
        chk("reen_held", bus.key_held, 1);

        // Asynchronous reset mid-scan, away from any clock edge.
        repeat (5) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_key_col", bus.key_col, 4'hF);
        chk("arst_held", bus.key_held, 0);
        chk("arst_code", bus.key_code, 0);
        chk("arst_valid", bus.key_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("arst_restart_col0", bus.key_col, 4'hE);
        step();
        chk("arst_restart_hold", bus.key_col, 4'hE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 Parameter NUM_COLS, default 4: number of matrix columns, 2..8.
REQ-002 Parameter NUM_ROWS, default 5: number of matrix rows, 2..8.
REQ-003 Parameter SCAN_DIV, default 1000: clk cycles each column is driven, >=2.
REQ-004 Parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames required to accept a change, 1..15.
REQ-005 Parameter REPEAT_FRAMES, default 32: auto-repeat period in frames, >=1; used only with KEYPAD_SCAN_REPEAT_EN.
REQ-006 clk  input  1  clock; all logic is on the rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  scan enable; high to scan.
REQ-009 key_row  input  NUM_ROWS  row sense lines, active-low, asynchronous to clk.
REQ-010 key_col  output  NUM_COLS  column drive, active-low one-cold.
REQ-011 key_code  output  CW=$clog2(NUM_ROWS*NUM_COLS)  accepted key index, col*NUM_ROWS+row.
REQ-012 key_valid  output  1  one-cycle pulse when key_code is newly accepted or repeated.
REQ-013 key_release  output  1  one-cycle pulse when the held key is released.
REQ-014 key_held  output  1  level; high while an accepted key is pressed.

Function
REQ-015 The block SHALL pass key_row through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 FSM states SHALL be IDLE and SCAN; IDLE->SCAN when en=1; SCAN->IDLE on the first clk with en=0.
REQ-017 In IDLE, key_col SHALL be all ones.
REQ-018 In SCAN, key_col bit c SHALL be 0 and all other bits 1 for SCAN_DIV cycles, with c running 0,1,..,NUM_COLS-1 and wrapping to 0; the first SCAN cycle drives column 0.
REQ-019 Synchronized rows SHALL be sampled in the last dwell cycle of each column; a frame is NUM_COLS*SCAN_DIV cycles.
REQ-020 At frame end, the candidate SHALL be the lowest code with a pressed (0) row, or "none" if no row is pressed.
REQ-021 A stability counter SHALL increment (saturating) when the candidate equals the previous frame's candidate and reset to 1 otherwise.
REQ-022 When a non-none candidate differing from the accepted key reaches DEBOUNCE_FRAMES, key_code SHALL update, key_valid SHALL pulse on the next cycle, and key_held SHALL be set; a direct key-to-key change SHALL give no key_release pulse.
REQ-023 When none reaches DEBOUNCE_FRAMES while key_held=1, key_release SHALL pulse, key_held SHALL clear, and key_code SHALL hold its last value.
REQ-024 key_valid and key_release SHALL never be high in the same cycle.
REQ-025 SCAN->IDLE SHALL abandon the frame, clear the column index and counters, and clear key_held without a key_release pulse.

Reset
REQ-026 While rstn=0, the block SHALL hold state=IDLE, key_col all ones, key_code=0, key_valid=0, key_release=0, key_held=0, all counters 0, and synchronizer flops all ones.
REQ-027 Reset assertion mid-scan SHALL take effect immediately, independent of clk; after release, scanning restarts at column 0 if en=1.

Configuration
REQ-028 With macro KEYPAD_SCAN_REPEAT_EN defined, key_valid SHALL re-pulse with an unchanged key_code every REPEAT_FRAMES frames while the same key stays accepted and pressed; the first repeat comes REPEAT_FRAMES frames after acceptance.
REQ-029 Without KEYPAD_SCAN_REPEAT_EN, key_valid SHALL pulse exactly once per acceptance, and no repeat counter SHALL be synthesized.

Verification (NUM_COLS=4, NUM_ROWS=5, SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles)
REQ-030 en=1 after reset, no key pressed -> key_col cycles 1110,1101,1011,0111 with 4 cycles each and no pulses.
REQ-031 Hold row 2 while column 1 is driven, for 5 frames -> key_code=7 and a single key_valid pulse after the 3rd stable frame end; key_held=1.
REQ-032 Press row 2 col 1 for 2 frames only (bounce) -> no key_valid and key_held stays 0.
REQ-033 Press row 0/col 3 (code 15) and row 4/col 0 (code 4) together -> key_code=4; then release all keys -> key_release pulses after 3 empty frames and key_code stays 4.
REQ-034 Drop en mid-frame while key_held=1 -> key_col=1111 on the next cycle, key_held=0, and no key_release.
REQ-035 With KEYPAD_SCAN_REPEAT_EN and REPEAT_FRAMES=8, hold code 7 for 30 frames -> key_valid at acceptance and again every 8 frames (3 repeats total).
